mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
Multicycle MIPS control unit. It sits directly upstream of the 32-bit ALU and drives its 4-bit function select F, the operand-mux selects and every datapath write enable. It consumes the ALU's zero and blez_out flags to resolve beq/blez. Instruction latency is 3–5 cycles, one instruction in flight at a time.

Parameters:
ILLEGAL_TRAP, 0, 0 = an unsupported opcode/funct returns to FETCH (nop); 1 = enter HALT until reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
op  input  6  instruction[31:26] from the instruction register
funct  input  6  instruction[5:0]
zero  input  1  ALU zero flag
blez_out  input  1  ALU A<=0 flag
alucontrol  output  4  ALU F select
alusrca  output  1  0=PC, 1=register A
alusrcb  output  2  00=B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate<<2
pcsrc  output  2  00=ALU result, 01=ALUOut register, 10=jump target
iord  output  1  memory address: 0=PC, 1=ALUOut
irwrite  output  1  instruction register load
memwrite  output  1  data memory write
regdst  output  1  write register: 0=rt, 1=rd
memtoreg  output  1  writeback: 0=ALUOut, 1=memory data
regwrite  output  1  register file write
pcen  output  1  PC load = pcwrite | (branch & zero) | (blezbr & blez_out)
illegal  output  1  one-cycle pulse in DECODE when the instruction is unsupported
state  output  4  current state (debug)

Behaviour:
- ALU F encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 0101, SRL 1010.
- Supported op values:
  - R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010.
  - lw 100011, sw 101011, beq 000100, blez 000110, addi 001000, j 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, BLEZ, ADDIEX, ADDIWB, JUMP, HALT.
- Any output not listed for a state is 0.
- Moore outputs per state:
  - FETCH: iord=0, alusrcb=01, ADD, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11, ADD (precomputes the branch target).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, ADD.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct.
  - ALUWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BRANCH: alusrca=1, SUB, pcsrc=01, branch=1.
  - BLEZ: alusrca=1, ADD, pcsrc=01, blezbr=1.
  - JUMP: pcsrc=10, pcwrite=1.
  - HALT: all enables 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE→ MEMADR (lw/sw), EXECUTE (legal R-type), BRANCH (beq), BLEZ (blez), ADDIEX (addi), JUMP (j).
  - Illegal op or funct in DECODE → FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1); illegal=1 during that DECODE cycle.
  - MEMADR→MEMRD (lw) or MEMWR (sw). MEMRD→MEMWB.
  - EXECUTE→ALUWB. ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, BLEZ, JUMP → FETCH.
  - HALT→HALT.
- Instruction cycle counts: lw 5, sw/R-type/addi 4, beq/blez/j 3.
- Reset: when reset=0 at a rising edge, state←FETCH. While reset=0, irwrite, memwrite, regwrite and pcen are forced to 0 combinationally; all other outputs follow the FETCH decode. Reset asserted mid-instruction aborts it with no further writes. On the first edge with reset=1, FETCH is executed.
- beq not taken (zero=0) and blez not taken (blez_out=0): pcen=0 in that state; the PC keeps PC+4 written in FETCH.
- zero and blez_out are ignored in all states except BRANCH and BLEZ respectively.
- op and funct are sampled only in DECODE, EXECUTE and MEMADR. The IR is stable because irwrite is asserted only in FETCH.

Test Plan:
- reset=0 for 2 cycles with op=100011 → state=FETCH; regwrite=memwrite=irwrite=pcen=0. After release: 5 cycles FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in MEMWB.
- R-type funct=000010 (srl) → EXECUTE drives alucontrol=1010, alusrca=1, alusrcb=00. Funct=000000 → 0101. Funct=101010 → 0111. ALUWB has regdst=1 and regwrite=1.
- beq with zero=1 in BRANCH → alucontrol=0110, pcsrc=01, pcen=1. Repeat with zero=0 → pcen=0, and the next state is FETCH.
- blez with blez_out=1 → pcen=1 in BLEZ. With blez_out=0 → pcen=0. zero toggling during BLEZ has no effect.
- op=111111 with ILLEGAL_TRAP=0 → illegal=1 for one cycle in DECODE, then FETCH. With ILLEGAL_TRAP=1 → HALT held for 10 cycles with all enables 0, exited only by reset.
- sw: reset=0 asserted during MEMADR → no memwrite pulse ever; state=FETCH on the next edge.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore state machine that sequences the ALU,
// the operand muxes and the datapath write enables, one instruction in flight at a time.
module mips_mc_controller #(
    parameter logic ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       blez_out,
    output logic [3:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    // state    | meaning
    // FETCH    | read instruction into IR, PC <= PC+4
    // DECODE   | decode op/funct, precompute branch target into ALUOut
    // MEMADR   | compute lw/sw effective address
    // MEMRD    | read data memory at ALUOut
    // MEMWB    | write memory data to rt
    // MEMWR    | write B to data memory at ALUOut
    // EXECUTE  | R-type ALU operation
    // ALUWB    | write ALUOut to rd
    // BRANCH   | beq compare, load PC from ALUOut if equal
    // BLEZ     | blez test, load PC from ALUOut if A<=0
    // ADDIEX   | A + sign-extended immediate
    // ADDIWB   | write ALUOut to rt
    // JUMP     | load PC with jump target
    // HALT     | trapped on unsupported instruction, left only by reset
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_BLEZ    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b1010;

    state_t state_q;
    state_t state_d;

    logic       funct_legal;
    logic [3:0] funct_alu;
    logic       pcwrite;
    logic       branch;
    logic       blezbr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            FN_SLL:  funct_alu = ALU_SLL;
            FN_SRL:  funct_alu = ALU_SRL;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alucontrol = ALU_AND;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        blezbr     = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_legal ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BLEZ:      state_d = S_BLEZ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
                if ((op == OP_RTYPE && !funct_legal) ||
                    !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BLEZ, OP_ADDI, OP_J})) begin
                    illegal = 1'b1;
                    state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BLEZ: begin
                alusrca    = 1'b1;
                alucontrol = ALU_ADD;
                pcsrc      = 2'b01;
                blezbr     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // In reset the datapath sees the FETCH mux settings but no write may happen.
        if (!reset) begin
            alucontrol = ALU_ADD;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            pcsrc      = 2'b00;
            iord       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            illegal    = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            blezbr     = 1'b0;
        end
    end

    assign pcen  = pcwrite | (branch & zero) | (blezbr & blez_out);
    assign state = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: two instances (no trap / trap) driven in lockstep,
// checked every cycle against a per-instruction state-sequence model.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       blez_out;

    logic [3:0] alucontrol_w [2];
    logic       alusrca_w    [2];
    logic [1:0] alusrcb_w    [2];
    logic [1:0] pcsrc_w      [2];
    logic       iord_w       [2];
    logic       irwrite_w    [2];
    logic       memwrite_w   [2];
    logic       regdst_w     [2];
    logic       memtoreg_w   [2];
    logic       regwrite_w   [2];
    logic       pcen_w       [2];
    logic       illegal_w    [2];
    logic [3:0] state_w      [2];
    logic [20:0] obs         [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mips_mc_controller #(.ILLEGAL_TRAP(g == 1)) dut (
            .clk        (clk),
            .reset      (reset),
            .op         (op),
            .funct      (funct),
            .zero       (zero),
            .blez_out   (blez_out),
            .alucontrol (alucontrol_w[g]),
            .alusrca    (alusrca_w[g]),
            .alusrcb    (alusrcb_w[g]),
            .pcsrc      (pcsrc_w[g]),
            .iord       (iord_w[g]),
            .irwrite    (irwrite_w[g]),
            .memwrite   (memwrite_w[g]),
            .regdst     (regdst_w[g]),
            .memtoreg   (memtoreg_w[g]),
            .regwrite   (regwrite_w[g]),
            .pcen       (pcen_w[g]),
            .illegal    (illegal_w[g]),
            .state      (state_w[g])
        );
        assign obs[g] = {state_w[g], alucontrol_w[g], alusrca_w[g], alusrcb_w[g], pcsrc_w[g],
                         iord_w[g], irwrite_w[g], memwrite_w[g], regdst_w[g], memtoreg_w[g],
                         regwrite_w[g], pcen_w[g], illegal_w[g]};
    end

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,
                           ST_MEMRD = 4'd3,  ST_MEMWB = 4'd4,   ST_MEMWR = 4'd5,
                           ST_EXECUTE = 4'd6, ST_ALUWB = 4'd7,  ST_BRANCH = 4'd8,
                           ST_BLEZ = 4'd9,   ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11,
                           ST_JUMP = 4'd12,  ST_HALT = 4'd13;

    localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                           O_BEQ = 6'b000100, O_BLEZ = 6'b000110, O_ADDI = 6'b001000,
                           O_J = 6'b000010;
    localparam logic [5:0] OPS [7]    = '{O_R, O_LW, O_SW, O_BEQ, O_BLEZ, O_ADDI, O_J};
    localparam logic [5:0] FUNCTS [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                          6'b101010, 6'b000000, 6'b000010};

    function automatic logic [3:0] alu_for(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b000000: return 4'b0101;
            6'b000010: return 4'b1010;
            default:   return 4'bxxxx;
        endcase
    endfunction

    // Expected output word for a given state, straight from the per-state output table.
    function automatic logic [20:0] model(input logic [3:0] st, input logic rn, input logic [5:0] f,
                                          input logic z, input logic bz, input logic ill);
        logic [3:0] ac;
        logic       sa, io, irw, mw, rd, m2r, rw, pe, il;
        logic [1:0] sb, ps;
        ac = 4'b0000; sa = 0; sb = 2'b00; ps = 2'b00; io = 0; irw = 0; mw = 0;
        rd = 0; m2r = 0; rw = 0; pe = 0; il = 0;
        if (!rn) begin
            ac = 4'b0010; sb = 2'b01;
        end else begin
            case (st)
                ST_FETCH:               begin sb = 2'b01; ac = 4'b0010; irw = 1; pe = 1; end
                ST_DECODE:              begin sb = 2'b11; ac = 4'b0010; il = ill; end
                ST_MEMADR, ST_ADDIEX:   begin sa = 1; sb = 2'b10; ac = 4'b0010; end
                ST_MEMRD:               io = 1;
                ST_MEMWB:               begin m2r = 1; rw = 1; end
                ST_MEMWR:               begin io = 1; mw = 1; end
                ST_EXECUTE:             begin sa = 1; ac = alu_for(f); end
                ST_ALUWB:               begin rd = 1; rw = 1; end
                ST_ADDIWB:              rw = 1;
                ST_BRANCH:              begin sa = 1; ac = 4'b0110; ps = 2'b01; pe = z; end
                ST_BLEZ:                begin sa = 1; ac = 4'b0010; ps = 2'b01; pe = bz; end
                ST_JUMP:                begin ps = 2'b10; pe = 1; end
                default:                ;
            endcase
        end
        return {st, ac, sa, sb, ps, io, irw, mw, rd, m2r, rw, pe, il};
    endfunction

    // One clock cycle: drive at posedge+1, check both instances at the negedge.
    task automatic cyc(input logic [3:0] s0, input logic [3:0] s1, input logic rn,
                       input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic bz, input logic ill, input string tag);
        logic [20:0] exp;
        reset = rn; op = o; funct = f; zero = z; blez_out = bz;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            exp = model((g == 0) ? s0 : s1, rn, f, z, bz, ill);
            total++;
            assert (obs[g] === exp) else begin
                bad++;
                $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, obs[g], exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Runs one legal instruction; the expected state list follows from its class and latency.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zb,
                             input logic bzb, input bit rnd, input string tag);
        logic [3:0] q[$];
        logic z, b;
        q = {};
        q.push_back(ST_FETCH);
        q.push_back(ST_DECODE);
        case (o)
            O_LW:    begin q.push_back(ST_MEMADR); q.push_back(ST_MEMRD); q.push_back(ST_MEMWB); end
            O_SW:    begin q.push_back(ST_MEMADR); q.push_back(ST_MEMWR); end
            O_R:     begin q.push_back(ST_EXECUTE); q.push_back(ST_ALUWB); end
            O_ADDI:  begin q.push_back(ST_ADDIEX); q.push_back(ST_ADDIWB); end
            O_BEQ:   q.push_back(ST_BRANCH);
            O_BLEZ:  q.push_back(ST_BLEZ);
            default: q.push_back(ST_JUMP);
        endcase
        for (int i = 0; i < q.size(); i++) begin
            z = 1'($urandom);
            b = 1'($urandom);
            if (!rnd && q[i] == ST_BRANCH) z = zb;
            if (!rnd && q[i] == ST_BLEZ) b = bzb;
            if (i == 0) cyc(q[i], q[i], 1'b1, 6'($urandom), 6'($urandom), z, b, 1'b0, tag);
            else        cyc(q[i], q[i], 1'b1, o, f, z, b, 1'b0, tag);
        end
    endtask

    initial begin
        int k;
        logic [5:0] ro, rf;
        reset = 1'b0; op = O_LW; funct = 6'b0; zero = 1'b0; blez_out = 1'b0;
        @(posedge clk);
        #1;
        cyc(ST_FETCH, ST_FETCH, 1'b0, O_LW, 6'b0, 1'b1, 1'b1, 1'b0, "reset_hold");
        run_instr(O_LW, 6'b0, 0, 0, 1, "lw_after_reset");

        run_instr(O_R, 6'b000010, 0, 0, 1, "srl");
        run_instr(O_R, 6'b000000, 0, 0, 1, "sll");
        run_instr(O_R, 6'b101010, 0, 0, 1, "slt");
        run_instr(O_BEQ, 6'b0, 1, 0, 0, "beq_taken");
        run_instr(O_BEQ, 6'b0, 0, 1, 0, "beq_not_taken");
        run_instr(O_BLEZ, 6'b0, 1, 1, 0, "blez_taken");
        run_instr(O_BLEZ, 6'b0, 0, 0, 0, "blez_not_taken");
        run_instr(O_ADDI, 6'b0, 0, 0, 1, "addi");
        run_instr(O_SW, 6'b0, 0, 0, 1, "sw");
        run_instr(O_J, 6'b0, 0, 0, 1, "j");

        // sw aborted by reset in MEMADR: no MEMWR may follow
        cyc(ST_FETCH, ST_FETCH, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, "sw_abort_f");
        cyc(ST_DECODE, ST_DECODE, 1'b1, O_SW, 6'b0, 1'b1, 1'b1, 1'b0, "sw_abort_d");
        cyc(ST_MEMADR, ST_MEMADR, 1'b0, O_SW, 6'b0, 1'b1, 1'b1, 1'b0, "sw_abort_rst");
        cyc(ST_FETCH, ST_FETCH, 1'b0, O_SW, 6'b0, 1'b1, 1'b1, 1'b0, "sw_abort_after");
        run_instr(O_SW, 6'b0, 0, 0, 1, "sw_restart");

        // unsupported opcode: instance 0 returns to FETCH, instance 1 halts
        cyc(ST_FETCH, ST_FETCH, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0, "ill_f");
        cyc(ST_DECODE, ST_DECODE, 1'b1, 6'b111111, 6'b0, 1'b1, 1'b1, 1'b1, "ill_decode");
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 0)
                cyc(ST_FETCH, ST_HALT, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom),
                    1'($urandom), 1'b1, "halt_hold");
            else
                cyc(ST_DECODE, ST_HALT, 1'b1, O_R, 6'b001000, 1'($urandom),
                    1'($urandom), 1'b1, "halt_hold_badfunct");
        end
        cyc(ST_FETCH, ST_HALT, 1'b0, O_LW, 6'b0, 1'b1, 1'b1, 1'b0, "halt_reset");
        run_instr(O_LW, 6'b0, 0, 0, 1, "lw_after_halt");

        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 6);
            ro = OPS[k];
            rf = (ro == O_R) ? FUNCTS[$urandom_range(0, 6)] : 6'($urandom);
            run_instr(ro, rf, 0, 0, 1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
